// File: rtl/demux1to4_buf_pkg.sv
// Shared constants for the registered 1-to-4 demultiplexer and its channel slots.
package demux1to4_buf_pkg;

  localparam int unsigned N_CH      = 4;
  localparam int unsigned SEL_W     = 2;
  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CNT_W = 16;

endpackage

// File: rtl/demux_slot.sv
// One output channel: a single-word buffer with valid flag and a delivery counter.
module demux_slot
  import demux1to4_buf_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             valid_d, valid_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             drain;

  assign drain = valid_q & out_ready_i;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (drain) begin
      valid_d = 1'b0;
      cnt_d   = cnt_q + CNT_W'(1);
    end
    // A load in the same cycle as a drain wins, giving back-to-back pass-through.
    if (load_i) begin
      data_d  = in_data_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/demux1to4_buf.sv
// Registered 1-to-4 demultiplexer: steers each accepted word into one of four buffered channels.
module demux1to4_buf
  import demux1to4_buf_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] select,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [N_CH-1:0]  out_valid,
  input  logic [N_CH-1:0]  out_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
);

  logic [WIDTH-1:0] data_w [N_CH];
  logic [CNT_W-1:0] cnt_w  [N_CH];
  logic [N_CH-1:0]  load;
  logic             accept;

  // Readiness looks only at the addressed channel so a stalled sink never blocks the others.
  assign in_ready = ~out_valid[select] | out_ready[select];
  assign accept   = in_valid & in_ready;

  for (genvar i = 0; i < N_CH; i++) begin : g_slot
    assign load[i] = accept & (select == SEL_W'(i));

    demux_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk         (clk),
      .rst         (rst),
      .load_i      (load[i]),
      .in_data_i   (in_data),
      .out_ready_i (out_ready[i]),
      .data_o      (data_w[i]),
      .valid_o     (out_valid[i]),
      .cnt_o       (cnt_w[i])
    );
  end

  assign out0 = data_w[0];
  assign out1 = data_w[1];
  assign out2 = data_w[2];
  assign out3 = data_w[3];
  assign cnt0 = cnt_w[0];
  assign cnt1 = cnt_w[1];
  assign cnt2 = cnt_w[2];
  assign cnt3 = cnt_w[3];

endmodule

// File: tb/tb_demux1to4_buf.sv
// Scoreboard bench for demux1to4_buf: driver queues expected words, monitor checks them on drain.
module tb_demux1to4_buf;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    select;
  logic [W-1:0]  out0, out1, out2, out3;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [CW-1:0] cnt0, cnt1, cnt2, cnt3;

  logic [W-1:0]  out_w [4];
  logic [CW-1:0] cnt_w [4];
  logic [W-1:0]  exp_q [4][$];

  int n_vec = 0;
  int n_bad = 0;

  demux1to4_buf #(
    .WIDTH (W),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .select    (select),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cnt0      (cnt0),
    .cnt1      (cnt1),
    .cnt2      (cnt2),
    .cnt3      (cnt3)
  );

  always #5 clk = ~clk;

  assign out_w[0] = out0;
  assign out_w[1] = out1;
  assign out_w[2] = out2;
  assign out_w[3] = out3;
  assign cnt_w[0] = cnt0;
  assign cnt_w[1] = cnt1;
  assign cnt_w[2] = cnt2;
  assign cnt_w[3] = cnt3;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every drain handshake must present the oldest queued word for that channel.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_ch%0d: got %h, expected no word", i, out_w[i]);
          end else begin
            chk($sformatf("drain_ch%0d", i), out_w[i], exp_q[i].pop_front());
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  // Present one word; called just after a rising edge, returns just after the next one.
  task automatic send(input int ch, input logic [W-1:0] d, input logic exp_rdy);
    in_valid = 1'b1;
    select   = 2'(ch);
    in_data  = d;
    @(negedge clk);
    chk($sformatf("in_ready_ch%0d", ch), W'(in_ready), W'(exp_rdy));
    if (exp_rdy) exp_q[ch].push_back(d);
    step();
  endtask

  task automatic chk_cnts(input string tag, input int c0, input int c1, input int c2,
                          input int c3);
    chk({tag, "_cnt0"}, W'(cnt0), W'(c0));
    chk({tag, "_cnt1"}, W'(cnt1), W'(c1));
    chk({tag, "_cnt2"}, W'(cnt2), W'(c2));
    chk({tag, "_cnt3"}, W'(cnt3), W'(c3));
  endtask

  task automatic chk_empty(input string tag);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_q%0d_left", tag, i), W'(exp_q[i].size()), '0);
  endtask

  initial begin
    // Reset held two cycles while a word is offered
    rst       = 1'b1;
    in_valid  = 1'b1;
    select    = 2'd1;
    in_data   = 32'h5555_5555;
    out_ready = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", W'(out_valid), '0);
    for (int i = 0; i < 4; i++) chk($sformatf("rst_out%0d", i), out_w[i], '0);
    chk_cnts("rst", 0, 0, 0, 0);
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    select   = 2'd0;
    @(negedge clk);
    chk("post_rst_in_ready", W'(in_ready), W'(1'b1));
    step();

    // Steering to each channel with all consumers ready
    out_ready = 4'b1111;
    send(0, 32'h0000_00ff, 1'b1);
    send(1, 32'h0000_ffff, 1'b1);
    send(2, 32'h00ff_ffff, 1'b1);
    send(3, 32'hffff_ffff, 1'b1);
    idle(2);
    @(negedge clk);
    chk_cnts("steer", 1, 1, 1, 1);
    chk("steer_out_valid", W'(out_valid), '0);
    chk_empty("steer");
    step();

    // Backpressure on ch2 must not block ch1
    out_ready = 4'b1011;
    send(2, 32'h00ff_ffff, 1'b1);
    send(2, 32'h1234_5678, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("stall_out2", out2, 32'h00ff_ffff);
    chk("stall_valid2", W'(out_valid[2]), W'(1'b1));
    step();
    send(1, 32'h0000_ffff, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("iso_valid1", W'(out_valid[1]), W'(1'b1));
    chk("iso_out2_hold", out2, 32'h00ff_ffff);
    step();

    // Back-to-back pass-through on ch3
    out_ready = 4'b0011;
    send(3, 32'h0000_000a, 1'b1);
    out_ready = 4'b1011;
    send(3, 32'h0000_000b, 1'b1);
    in_valid  = 1'b0;
    out_ready = 4'b0011;
    @(negedge clk);
    chk("pass_out3", out3, 32'h0000_000b);
    chk("pass_valid3", W'(out_valid[3]), W'(1'b1));
    chk("pass_cnt3", W'(cnt3), W'(2));
    chk("pass_cnt1", W'(cnt1), W'(2));
    step();

    // Counter wrap on ch0 (4-bit counter, starts at 1)
    for (int k = 0; k < 14; k++) send(0, 32'hc000_0000 + W'(k), 1'b1);
    idle(2);
    @(negedge clk);
    chk("wrap_cnt0_15", W'(cnt0), W'(15));
    step();
    send(0, 32'hc000_0100, 1'b1);
    idle(2);
    @(negedge clk);
    chk("wrap_cnt0_0", W'(cnt0), W'(0));
    step();
    send(0, 32'hc000_0101, 1'b1);
    idle(2);
    @(negedge clk);
    chk("wrap_cnt0_1", W'(cnt0), W'(1));
    chk("wrap_q0_left", W'(exp_q[0].size()), '0);
    step();

    // Mid-operation reset with a coincident accept to ch1 and drain on ch0
    out_ready = 4'b0000;
    send(0, 32'hd0d0_d0d0, 1'b1);
    rst       = 1'b1;
    in_valid  = 1'b1;
    select    = 2'd1;
    in_data   = 32'heeee_eeee;
    out_ready = 4'b0001;
    step();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    @(negedge clk);
    chk("mrst_out_valid", W'(out_valid), '0);
    for (int i = 0; i < 4; i++) chk($sformatf("mrst_out%0d", i), out_w[i], '0);
    chk_cnts("mrst", 0, 0, 0, 0);
    step();

    // Fill all four, then drain all four in one cycle
    send(0, 32'hf000_0000, 1'b1);
    send(1, 32'hf111_1111, 1'b1);
    send(2, 32'hf222_2222, 1'b1);
    send(3, 32'hf333_3333, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("fill_out_valid", W'(out_valid), W'(4'b1111));
    step();
    out_ready = 4'b1111;
    idle(2);
    @(negedge clk);
    chk("final_out_valid", W'(out_valid), '0);
    chk_cnts("final", 1, 1, 1, 1);
    chk_empty("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
